// File: rtl/gray_sum_block.sv
`default_nettype none
// ============================================================================
// Module      : gray_sum_block
// Description : Gathers the three weighted FP32 channel products (red, green,
//               blue), each arriving with its own valid flag, then computes
//               (Red + Green) + Blue with one shared two-cycle FP32 adder
//               (align cycle, normalise cycle). Presents the gray value with a
//               one-cycle valid pulse.
// Options     : `define ROUND_NEAREST_EN -> round to nearest, ties to even.
//               Default build truncates.
// Ports       : CLK        - clock, rising edge
//               RST        - synchronous active-high reset
//               Red_In     - weighted red product (FP32)
//               Green_In   - weighted green product (FP32)
//               Blue_In    - weighted blue product (FP32)
//               Flag_Red   - red product valid (level or pulse)
//               Flag_Green - green product valid
//               Flag_Blue  - blue product valid
//               Gray_Out   - FP32 gray sum, held between results
//               Gray_Valid - one-cycle pulse when Gray_Out updates
//               Busy       - adder running; flags ignored while high
// Revision    : 1.0 - initial release
// ============================================================================
module gray_sum_block #(
    parameter logic [31:0] SAT_VALUE = 32'h7F7FFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Red_In,
    input  logic [31:0] Green_In,
    input  logic [31:0] Blue_In,
    input  logic        Flag_Red,
    input  logic        Flag_Green,
    input  logic        Flag_Blue,
    output logic [31:0] Gray_Out,
    output logic        Gray_Valid,
    output logic        Busy
);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_ADD1A   = 3'd1,
        S_ADD1N   = 3'd2,
        S_ADD2A   = 3'd3,
        S_ADD2N   = 3'd4
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [2:0]  r_cap_q,   w_cap_d;      // {blue, green, red} captured
    logic [30:0] r_red_q,   w_red_d;      // sign bits are never needed
    logic [30:0] r_green_q, w_green_d;
    logic [30:0] r_blue_q,  w_blue_d;
    logic [30:0] r_part_q,  w_part_d;     // Red + Green partial sum
    logic [24:0] r_sum_q,   w_sum_d;      // aligned mantissa sum incl. carry
    logic [7:0]  r_exp_q,   w_exp_d;      // exponent of the larger operand
    logic [31:0] r_gray_q,  w_gray_d;
    logic        r_valid_q, w_valid_d;

    // Exponent 255 operands behave as the largest finite value.
    function automatic logic [30:0] f_clean(input logic [30:0] v);
        f_clean = (v[30:23] == 8'hFF) ? SAT_VALUE[30:0] : v;
    endfunction

    // ------------------------------------------------------------------
    // Align stage: operand select, ordering, shift and add
    // ------------------------------------------------------------------
    logic [30:0] w_op_x, w_op_y;
    logic [7:0]  w_exp_x, w_exp_y, w_exp_big, w_diff;
    logic [23:0] w_mant_x, w_mant_y, w_mant_big, w_mant_small, w_aligned;
    logic [24:0] w_sum;
`ifdef ROUND_NEAREST_EN
    logic [2:0]  r_grs_q, w_grs_d, w_grs;  // guard, round, sticky
    logic [47:0] w_shift;
`endif

    always_comb begin
        w_op_x   = f_clean((r_state_q == S_ADD2A) ? r_part_q : r_red_q);
        w_op_y   = f_clean((r_state_q == S_ADD2A) ? r_blue_q : r_green_q);
        w_exp_x  = w_op_x[30:23];
        w_exp_y  = w_op_y[30:23];
        // Exponent zero flushes to zero (no denormals).
        w_mant_x = (w_exp_x == 8'd0) ? 24'd0 : {1'b1, w_op_x[22:0]};
        w_mant_y = (w_exp_y == 8'd0) ? 24'd0 : {1'b1, w_op_y[22:0]};
        if (w_exp_x >= w_exp_y) begin
            w_exp_big    = w_exp_x;
            w_mant_big   = w_mant_x;
            w_mant_small = w_mant_y;
            w_diff       = w_exp_x - w_exp_y;
        end else begin
            w_exp_big    = w_exp_y;
            w_mant_big   = w_mant_y;
            w_mant_small = w_mant_x;
            w_diff       = w_exp_y - w_exp_x;
        end
`ifdef ROUND_NEAREST_EN
        w_shift = {w_mant_small, 24'd0} >> w_diff;
        if (w_diff < 8'd24) begin
            w_aligned = w_shift[47:24];
            w_grs     = {w_shift[23], w_shift[22], |w_shift[21:0]};
        end else begin
            // Far-away operand only survives as sticky.
            w_aligned = 24'd0;
            w_grs     = {2'b00, |w_mant_small};
        end
`else
        // A shift of 24 or more already yields zero.
        w_aligned = w_mant_small >> w_diff;
`endif
        w_sum = {1'b0, w_mant_big} + {1'b0, w_aligned};
    end

    // ------------------------------------------------------------------
    // Normalise stage: carry shift, optional rounding, saturation
    // ------------------------------------------------------------------
    logic [8:0]  w_nexp;
    logic [23:0] w_nmant;
    logic [30:0] w_result;
`ifdef ROUND_NEAREST_EN
    logic        w_guard, w_round, w_sticky;
    logic [24:0] w_rmant;
`endif

    always_comb begin
        if (r_sum_q[24]) begin
            w_nmant = r_sum_q[24:1];
            w_nexp  = {1'b0, r_exp_q} + 9'd1;
        end else begin
            w_nmant = r_sum_q[23:0];
            w_nexp  = {1'b0, r_exp_q};
        end
`ifdef ROUND_NEAREST_EN
        if (r_sum_q[24]) begin
            w_guard  = r_sum_q[0];
            w_round  = r_grs_q[2];
            w_sticky = r_grs_q[1] | r_grs_q[0];
        end else begin
            w_guard  = r_grs_q[2];
            w_round  = r_grs_q[1];
            w_sticky = r_grs_q[0];
        end
        w_rmant = {1'b0, w_nmant};
        if (w_guard && (w_round || w_sticky || w_nmant[0])) begin
            w_rmant = {1'b0, w_nmant} + 25'd1;
        end
        // Rounding overflow: mantissa became 2.0, renormalise.
        if (w_rmant[24]) begin
            w_nmant = 24'h800000;
            w_nexp  = w_nexp + 9'd1;
        end else begin
            w_nmant = w_rmant[23:0];
        end
`endif
        if (r_sum_q == 25'd0) begin
            w_result = 31'd0;
        end else if (w_nexp >= 9'd255) begin
            w_result = SAT_VALUE[30:0];
        end else begin
            w_result = {w_nexp[7:0], w_nmant[22:0]};
        end
    end

    // ------------------------------------------------------------------
    // Control: capture and sequencing
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_cap_d   = r_cap_q;
        w_red_d   = r_red_q;
        w_green_d = r_green_q;
        w_blue_d  = r_blue_q;
        w_part_d  = r_part_q;
        w_sum_d   = r_sum_q;
        w_exp_d   = r_exp_q;
        w_gray_d  = r_gray_q;
        w_valid_d = 1'b0;
`ifdef ROUND_NEAREST_EN
        w_grs_d   = r_grs_q;
`endif
        case (r_state_q)
            S_COLLECT: begin
                // First capture per channel wins until the result is out.
                if (Flag_Red && !r_cap_q[0]) begin
                    w_red_d    = Red_In[30:0];
                    w_cap_d[0] = 1'b1;
                end
                if (Flag_Green && !r_cap_q[1]) begin
                    w_green_d  = Green_In[30:0];
                    w_cap_d[1] = 1'b1;
                end
                if (Flag_Blue && !r_cap_q[2]) begin
                    w_blue_d   = Blue_In[30:0];
                    w_cap_d[2] = 1'b1;
                end
                if (w_cap_d == 3'b111) begin
                    w_state_d = S_ADD1A;
                end
            end
            S_ADD1A, S_ADD2A: begin
                w_sum_d   = w_sum;
                w_exp_d   = w_exp_big;
`ifdef ROUND_NEAREST_EN
                w_grs_d   = w_grs;
`endif
                w_state_d = (r_state_q == S_ADD1A) ? S_ADD1N : S_ADD2N;
            end
            S_ADD1N: begin
                w_part_d  = w_result;
                w_state_d = S_ADD2A;
            end
            S_ADD2N: begin
                w_gray_d  = {1'b0, w_result};
                w_valid_d = 1'b1;
                w_cap_d   = 3'b000;
                w_state_d = S_COLLECT;
            end
            default: begin
                w_state_d = S_COLLECT;
                w_cap_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= S_COLLECT;
            r_cap_q   <= 3'b000;
            r_red_q   <= 31'd0;
            r_green_q <= 31'd0;
            r_blue_q  <= 31'd0;
            r_part_q  <= 31'd0;
            r_sum_q   <= 25'd0;
            r_exp_q   <= 8'd0;
            r_gray_q  <= 32'd0;
            r_valid_q <= 1'b0;
`ifdef ROUND_NEAREST_EN
            r_grs_q   <= 3'b000;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_cap_q   <= w_cap_d;
            r_red_q   <= w_red_d;
            r_green_q <= w_green_d;
            r_blue_q  <= w_blue_d;
            r_part_q  <= w_part_d;
            r_sum_q   <= w_sum_d;
            r_exp_q   <= w_exp_d;
            r_gray_q  <= w_gray_d;
            r_valid_q <= w_valid_d;
`ifdef ROUND_NEAREST_EN
            r_grs_q   <= w_grs_d;
`endif
        end
    end

    assign Gray_Out   = r_gray_q;
    assign Gray_Valid = r_valid_q;
    assign Busy       = (r_state_q != S_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_gray_sum_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_sum_block
// Description : Directed self-checking bench for gray_sum_block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_sum_block;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Red_In = 32'd0, Green_In = 32'd0, Blue_In = 32'd0;
    logic        Flag_Red = 1'b0, Flag_Green = 1'b0, Flag_Blue = 1'b0;
    logic [31:0] Gray_Out;
    logic        Gray_Valid;
    logic        Busy;

    int n_checks = 0;
    int n_err    = 0;

    gray_sum_block dut (
        .CLK        (CLK),
        .RST        (RST),
        .Red_In     (Red_In),
        .Green_In   (Green_In),
        .Blue_In    (Blue_In),
        .Flag_Red   (Flag_Red),
        .Flag_Green (Flag_Green),
        .Flag_Blue  (Flag_Blue),
        .Gray_Out   (Gray_Out),
        .Gray_Valid (Gray_Valid),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Advance one clock edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Present a full triple in one cycle, then wait (bounded) for the result.
    // Returns sampled in the Gray_Valid cycle.
    task automatic run_triple(input logic [31:0] r, input logic [31:0] g,
                              input logic [31:0] b, input logic [31:0] want,
                              input string tag);
        int n;
        Red_In = r; Green_In = g; Blue_In = b;
        Flag_Red = 1'b1; Flag_Green = 1'b1; Flag_Blue = 1'b1;
        step();
        Flag_Red = 1'b0; Flag_Green = 1'b0; Flag_Blue = 1'b0;
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        n = 0;
        while (!Gray_Valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd4);
        chk({tag, "_value"}, Gray_Out, want);
        chk({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        // ---------------- reset ----------------
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        chk("rst_gray",  Gray_Out, 32'h0);
        chk("rst_valid", {31'd0, Gray_Valid}, 32'd0);
        chk("rst_busy",  {31'd0, Busy}, 32'd0);

        // ---------------- 1 + 2 + 4 = 7 ----------------
        run_triple(32'h3F800000, 32'h40000000, 32'h40800000, 32'h40E00000, "sum7");
        step();
        chk("sum7_pulse_low", {31'd0, Gray_Valid}, 32'd0);
        chk("sum7_hold", Gray_Out, 32'h40E00000);

        // ---------------- staggered pulses, red re-pulse ignored ----------
        // 1.0 + 2.0 + 8.0 = 11.0; a late 16.0 red must not be used.
        for (int c = 0; c <= 12; c++) begin
            Flag_Red   = (c == 0) || (c == 5);
            Red_In     = (c == 5) ? 32'h41800000 : 32'h3F800000;
            Flag_Green = (c == 3);
            Green_In   = 32'h40000000;
            Flag_Blue  = (c == 7);
            Blue_In    = 32'h41000000;
            step();
            chk($sformatf("stagger_valid_c%0d", c), {31'd0, Gray_Valid}, {31'd0, c == 11});
            if (c == 11) chk("stagger_value", Gray_Out, 32'h41300000);
        end
        Flag_Red = 1'b0; Flag_Green = 1'b0; Flag_Blue = 1'b0;

        // ---------------- rounding case ----------------
`ifdef ROUND_NEAREST_EN
        run_triple(32'h4B800000, 32'h40400000, 32'h00000000, 32'h4B800002, "round");
`else
        run_triple(32'h4B800000, 32'h40400000, 32'h00000000, 32'h4B800001, "round");
`endif

        // ---------------- zeros, then saturation (back-to-back) ----------
        run_triple(32'h0, 32'h0, 32'h0, 32'h00000000, "zero");
        run_triple(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, "sat");

        // ---------------- reset during ADD1N ----------------
        step();
        Red_In = 32'h3F800000; Green_In = 32'h40000000; Blue_In = 32'h40800000;
        Flag_Red = 1'b1; Flag_Green = 1'b1; Flag_Blue = 1'b1;
        step();                       // capture edge, now ADD1A
        Flag_Red = 1'b0; Flag_Green = 1'b0; Flag_Blue = 1'b0;
        step();                       // now ADD1N
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("midrst_busy",  {31'd0, Busy}, 32'd0);
        chk("midrst_gray",  Gray_Out, 32'h0);
        chk("midrst_valid", {31'd0, Gray_Valid}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Gray_Valid) pulses++;
        end
        chk("midrst_no_pulse", pulses, 32'd0);
        run_triple(32'h3F800000, 32'h40000000, 32'h40800000, 32'h40E00000, "after_rst");

        // ---------------- flags during Busy dropped; sign ignored --------
        step();
        Red_In = 32'hBF800000; Green_In = 32'h3F800000; Blue_In = 32'h3F800000;
        Flag_Red = 1'b1; Flag_Green = 1'b1; Flag_Blue = 1'b1;
        step();                       // capture edge
        Flag_Red = 1'b0; Flag_Green = 1'b0; Flag_Blue = 1'b0;
        step();
        Red_In = 32'h41000000; Green_In = 32'h41000000; Blue_In = 32'h41000000;
        Flag_Red = 1'b1; Flag_Green = 1'b1; Flag_Blue = 1'b1;
        step();
        Flag_Red = 1'b0; Flag_Green = 1'b0; Flag_Blue = 1'b0;
        step();
        step();
        chk("busyflag_valid", {31'd0, Gray_Valid}, 32'd1);
        chk("busyflag_value", Gray_Out, 32'h40400000);
        step();
        chk("busyflag_not_queued", {31'd0, Busy}, 32'd0);
        step();
        chk("busyflag_no_pulse", {31'd0, Gray_Valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_sum_block.md
Name: gray_sum_block

Overview:
- Consumer end of the channel-weighting stage in the RGB-to-gray path.
- Collects the three weighted FP32 channel products, each with its own completion flag, and sums them as (Red + Green) + Blue with an internal sequential FP32 adder.
- Presents one FP32 gray value with a one-cycle valid pulse.
- Sits between the per-channel multiplier stage and the gray output/storage stage.

Parameters:
- SAT_VALUE, 32'h7F7FFFFF, value driven on Gray_Out when the result exponent overflows (largest finite FP32).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- Red_In  input  32  weighted red product, FP32.
- Green_In  input  32  weighted green product, FP32.
- Blue_In  input  32  weighted blue product, FP32.
- Flag_Red  input  1  red product valid; level or pulse.
- Flag_Green  input  1  green product valid.
- Flag_Blue  input  1  blue product valid.
- Gray_Out  output  32  FP32 gray sum; holds its value between results.
- Gray_Valid  output  1  one-cycle pulse when Gray_Out updates.
- Busy  output  1  high while adding; flags are ignored while Busy is high.

Behaviour:
- Clock and reset: one clock (CLK); RST is synchronous and active-high.
- Reset values: state COLLECT, capture bits cleared, Gray_Out = 0, Gray_Valid = 0, Busy = 0.
- RST overrides everything in the same edge, including mid-addition; an in-flight sum is discarded and never reported.
- COLLECT state:
  - Each channel has a capture bit. On any edge where the channel's flag is 1 and its capture bit is 0, latch that channel's data and set the bit.
  - Later flag highs on an already-captured channel are ignored; the first capture wins.
  - Simultaneous flags are all captured in the same cycle.
  - When the last capture happens at edge T, the state moves to ADD1A at T.
- States and transitions: COLLECT -> ADD1A -> ADD1N -> ADD2A -> ADD2N -> COLLECT. Busy = 1 in every state except COLLECT.
  - ADD1A: align and add Red + Green.
  - ADD1N: normalise; result goes to the partial register.
  - ADD2A: align and add partial + Blue.
  - ADD2N: normalise; Gray_Out registered at the edge leaving ADD2N.
- Timing:
  - Gray_Valid is high in cycle T+4 through T+5 (exactly one cycle).
  - Capture bits clear on the same edge, so a new flag in the Gray_Valid cycle is captured.
  - Flags seen while Busy = 1 are dropped, not queued.
- Adder arithmetic (both operands are treated as non-negative):
  - Input sign bits are ignored; output sign is always 0.
  - An exponent of 0 means zero (denormals flush to 0). Exponent 255 inputs are treated as SAT_VALUE.
  - Order the operands so the larger exponent is first. Mantissas are 24-bit with the hidden 1.
  - Shift the smaller mantissa right by the exponent difference; a difference of 24 or more contributes 0 except as sticky.
  - The 25-bit sum is normalised: on carry, shift right 1 and add 1 to the exponent.
  - Default rounding is truncation.
  - A result exponent of 255 or more gives SAT_VALUE. Zero + zero gives 32'h00000000.

Optional Feature:
- Macro: ROUND_NEAREST_EN.
- When defined: each add keeps guard, round and sticky bits and rounds to nearest, ties to even. A rounding carry renormalises within the same N cycle, and saturation applies after rounding. Latency is unchanged.
- When undefined: truncation as above; the guard, round and sticky logic is absent.

Test Plan:
- Red = 32'h3F800000, Green = 32'h40000000, Blue = 32'h40800000, all flags together -> Gray_Out = 32'h40E00000 (7.0), one-cycle Gray_Valid 4 cycles after the capture edge.
- Flag_Red at cycle 0, Flag_Green at 3, Flag_Blue at 7 (pulses); re-pulse Flag_Red at 5 with different data -> the cycle-0 red value is used; Gray_Valid at cycle 11.
- Red = 32'h4B800000, Green = 32'h40400000, Blue = 0 -> 32'h4B800001 by default; 32'h4B800002 with ROUND_NEAREST_EN (tie goes to even).
- Red = Green = 32'h7F7FFFFF, Blue = 32'h3F800000 -> Gray_Out = 32'h7F7FFFFF; all inputs 0 -> 32'h00000000.
- All flags captured, RST asserted during ADD1N -> Gray_Valid never pulses, Busy = 0 and Gray_Out = 0 next cycle; a new triple then completes normally.
- Flags pulsed while Busy = 1 -> ignored; with Red_In sign bit set to 1 (32'hBF800000) plus 1.0 and 1.0 -> Gray_Out = 32'h40400000 (3.0).
